// File: rtl/wb_mem_arbiter.sv
// Round-robin two-master Wishbone classic arbiter sharing one memory bus.
// Optional ack watchdog is compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  ins_cyc_i,
  input  logic                  ins_stb_i,
  input  logic                  ins_we_i,
  input  logic [ADDR_WIDTH-1:0] ins_addr_i,
  input  logic [DATA_WIDTH-1:0] ins_data_i,
  output logic [DATA_WIDTH-1:0] ins_data_o,
  output logic                  ins_ack_o,
  input  logic                  dat_cyc_i,
  input  logic                  dat_stb_i,
  input  logic                  dat_we_i,
  input  logic [ADDR_WIDTH-1:0] dat_addr_i,
  input  logic [DATA_WIDTH-1:0] dat_data_i,
  output logic [DATA_WIDTH-1:0] dat_data_o,
  output logic                  dat_ack_o,
  output logic                  mem_cyc_o,
  output logic                  mem_stb_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_INS = 2'd1,
    GRANT_DAT = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_dat_q, last_dat_d;  // 1: data master was granted most recently
  logic   ins_req, dat_req;
  logic   tmo_fire;
  logic   eff_ack;

  assign ins_req = ins_cyc_i & ins_stb_i;
  assign dat_req = dat_cyc_i & dat_stb_i;
  assign eff_ack = mem_ack_i | tmo_fire;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] wd_q, wd_d;
  logic          timeout_q, timeout_d;
  logic          granted_cyc;

  // Counter runs only while the same grant persists; any exit or switch clears it.
  always_comb begin
    granted_cyc = 1'b0;
    if (state_q == GRANT_INS) granted_cyc = ins_cyc_i;
    if (state_q == GRANT_DAT) granted_cyc = dat_cyc_i;
    tmo_fire  = granted_cyc & ~mem_ack_i & (wd_q == WD_LAST);
    wd_d      = (granted_cyc & ~eff_ack) ? wd_q + 1'b1 : '0;
    timeout_d = timeout_q | tmo_fire;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_DATA, TIMEOUT_CYCLES};
  assign tmo_fire   = 1'b0;
  assign timeout_o  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_dat_d = last_dat_q;
    mem_cyc_o  = 1'b0;
    mem_stb_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    ins_ack_o  = 1'b0;
    dat_ack_o  = 1'b0;
    // Read data is a plain pass-through, masked so outputs read 0 in reset.
    ins_data_o = rst_n ? mem_data_i : '0;
    dat_data_o = rst_n ? mem_data_i : '0;

    case (state_q)
      IDLE: begin
        if (ins_req && dat_req) state_d = last_dat_q ? GRANT_INS : GRANT_DAT;
        else if (ins_req)       state_d = GRANT_INS;
        else if (dat_req)       state_d = GRANT_DAT;
      end
      GRANT_INS: begin
        mem_cyc_o  = ins_cyc_i & ~tmo_fire;
        mem_stb_o  = ins_stb_i & ~tmo_fire;
        mem_we_o   = ins_we_i;
        mem_addr_o = ins_addr_i;
        mem_data_o = ins_data_i;
        ins_ack_o  = eff_ack;
        if (tmo_fire) ins_data_o = TIMEOUT_DATA;
        if (eff_ack) begin
          last_dat_d = 1'b0;
          state_d    = dat_req ? GRANT_DAT : IDLE;
        end else if (!ins_cyc_i) begin
          state_d = IDLE;
        end
      end
      GRANT_DAT: begin
        mem_cyc_o  = dat_cyc_i & ~tmo_fire;
        mem_stb_o  = dat_stb_i & ~tmo_fire;
        mem_we_o   = dat_we_i;
        mem_addr_o = dat_addr_i;
        mem_data_o = dat_data_i;
        dat_ack_o  = eff_ack;
        if (tmo_fire) dat_data_o = TIMEOUT_DATA;
        if (eff_ack) begin
          last_dat_d = 1'b1;
          state_d    = ins_req ? GRANT_INS : IDLE;
        end else if (!dat_cyc_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_dat_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      last_dat_q <= last_dat_d;
    end
  end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Two-master Wishbone (classic, single-beat) arbiter that shares the single Controller memory bus (`core_*`) between a core's instruction-fetch port and its data port. It sits in `processorci_top` between the core instantiation and the Controller whenever a core exposes separate instruction and data buses but `ENABLE_SECOND_MEMORY` is not defined. Arbitration is round-robin with a registered grant. An optional watchdog terminates transactions the slave never acknowledges.

## Interface
- `ADDR_WIDTH`, 32, address width of all ports
- `DATA_WIDTH`, 32, data width of all ports
- `TIMEOUT_CYCLES`, 1024, cycles a granted transaction may wait for ack before forced termination (used only with the watchdog compiled in; minimum 2)
- `TIMEOUT_DATA`, 32'hDEAD_BEEF, read data returned on a forced termination

Ports:
- `sys_clk` in 1: single clock, rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `ins_cyc_i`, `ins_stb_i`, `ins_we_i` in 1 each: instruction master request
- `ins_addr_i` in ADDR_WIDTH; `ins_data_i` in DATA_WIDTH: instruction master address / write data
- `ins_data_o` out DATA_WIDTH; `ins_ack_o` out 1: instruction master read data / ack
- `dat_cyc_i`, `dat_stb_i`, `dat_we_i`, `dat_addr_i`, `dat_data_i`, `dat_data_o`, `dat_ack_o`: same set for the data master
- `mem_cyc_o`, `mem_stb_o`, `mem_we_o` out 1 each; `mem_addr_o` out ADDR_WIDTH; `mem_data_o` out DATA_WIDTH: to Controller
- `mem_data_i` in DATA_WIDTH; `mem_ack_i` in 1: from Controller
- `timeout_o` out 1: sticky watchdog flag

## Operation
- Request of master X: `X_cyc_i & X_stb_i`.
- States: IDLE, GRANT_INS, GRANT_DAT. A register `last` records the most recently granted master. Reset value of `last` is DAT, so INS wins the first tie.
- IDLE: if exactly one master requests, go to its GRANT state. If both request, grant the master that is not `last`. Otherwise stay in IDLE.
- GRANT_X, combinational routing:
  - `mem_cyc_o`/`mem_stb_o`/`mem_we_o`/`mem_addr_o`/`mem_data_o` = master X's signals.
  - `X_ack_o` = `mem_ack_i`.
  - `X_data_o` = `mem_data_i`.
- In IDLE, all `mem_*` outputs are 0.
- The non-granted master always sees ack 0. Its data output is `mem_data_i` (don't-care).
- GRANT_X exit conditions:
  - `mem_ack_i`=1: `last`←X. Go to GRANT of the other master if it is requesting in that cycle, else IDLE.
  - X drops `X_cyc_i` without ack (abort): go to IDLE. `mem_cyc_o` falls in the same cycle because it is combinational.
- `mem_ack_i` in IDLE is ignored and not forwarded.
- Reset, including mid-transaction: state←IDLE, `last`←DAT, `timeout_o`←0, watchdog counter←0. All outputs read 0 while `rst_n`=0.

## Timing
- Grant latency is 1 cycle. A request first seen at edge N is presented on `mem_*` after edge N+1.
- Ack path `mem_ack_i`→`X_ack_o` is combinational, with 0 added cycles. Read data is combinational as well.
- With contention, master switch-over costs 0 idle cycles. For back-to-back requests from the same master with no contention, 1 IDLE cycle separates the transactions.
- Under continuous contention, masters alternate strictly. No master waits for more than one other transaction.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to each GRANT state and increments each cycle while granted without ack.
  - When the count reaches TIMEOUT_CYCLES−1 with no ack, the arbiter does all of the following in that cycle:
    - drives `X_ack_o`=1 and `X_data_o`=TIMEOUT_DATA;
    - forces `mem_cyc_o`=`mem_stb_o`=0;
    - sets `timeout_o`=1 from the next edge until reset;
    - applies the normal ack exit rules.
  - A real ack on that same cycle takes precedence: real data is returned and `timeout_o` is not set.
- `WB_ARB_TIMEOUT_EN` undefined: no counter is built, `timeout_o` is tied 0, and a missing ack stalls the bus indefinitely.

## Test plan
- Single INS read of addr 0x0000_0100, Controller acks after 3 cycles with 0x1234_5678 → `mem_addr_o`=0x100 one cycle after request; `ins_ack_o`=1 with `ins_data_o`=0x1234_5678 in the same cycle as `mem_ack_i`; state returns to IDLE.
- Both masters request in the same cycle straight after reset (INS read 0x0, DAT write 0x8000_0000 data 0xA5A5_A5A5) → INS is served first; `mem_we_o`=1 and `mem_addr_o`=0x8000_0000 in the cycle after INS ack, with no gap.
- Both masters hold continuous requests for 8 transactions → grants alternate INS, DAT, INS, …; each gets exactly 4.
- DAT drops `dat_cyc_i` after 2 granted cycles without ack; then `mem_ack_i` pulses 1 → `mem_cyc_o`=0 in the drop cycle; the stray ack is not forwarded to either master.
- Assert `rst_n`=0 asynchronously mid-transaction while in GRANT_DAT → all outputs 0 immediately; after release the first tie goes to INS.
- Timeout: with `WB_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=16, the slave never acks an INS read → `ins_ack_o`=1 with data 0xDEAD_BEEF on the 16th granted cycle and `timeout_o`=1 thereafter. Without the macro, `ins_ack_o` stays 0 and `timeout_o` stays 0.
